// File: rtl/ipu_frame_sequencer.sv
// Frame-walk sequencer: preloads line-buffer rows from frame memory, then issues
// one convolution instruction per pixel to the coprocessor over req/wait/done.
module ipu_frame_sequencer #(
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 480,
  parameter int PPW     = 4,
  parameter int COORD_W = 9,
  parameter int MAX_K   = 5
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [3:0]                              opcode,
  input  logic [1:0]                              ksize,
  output logic [COORD_W+$clog2(IMG_W/PPW)-1:0]    buf_addr,
  output logic                                    buf_load,
  output logic [COORD_W-1:0]                      buf_col,
  output logic                                    next_matrix,
  output logic                                    conv_req,
  output logic [31:0]                             conv_inst,
  input  logic                                    conv_wait,
  input  logic                                    conv_done,
  output logic                                    busy,
  output logic                                    done,
  output logic [COORD_W-1:0]                      cur_h,
  output logic [COORD_W-1:0]                      cur_v
);

  localparam int WCOL_W = $clog2(IMG_W/PPW);

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_ISSUE, S_WAIT_DONE, S_ADV_ROW, S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_start_d;
  logic                r_next_matrix;
  logic [3:0]          r_opcode;
  logic [3:0]          r_rows_left;
  logic [COORD_W-1:0]  r_row;
  logic [WCOL_W-1:0]   r_wcol;
  logic [COORD_W-1:0]  r_h;
  logic [COORD_W-1:0]  r_v;

  logic                w_start_rise;
  logic [3:0]          w_k_raw;
  logic [3:0]          w_k;
  logic [COORD_W-1:0]  w_r0;
  logic [COORD_W-1:0]  w_row_inc;
  logic                w_last_word;
  logic                w_last_h;
  logic                w_last_v;

  assign w_start_rise = start & ~r_start_d;
  assign w_k_raw      = {2'b00, ksize} + 4'd2;
  assign w_k          = (w_k_raw > 4'(MAX_K)) ? 4'(MAX_K) : w_k_raw;
  // First preload row sits K/2 rows above row 0, wrapping to the frame bottom.
  assign w_r0         = COORD_W'(IMG_H) - COORD_W'(w_k >> 1);
  assign w_row_inc    = (r_row == COORD_W'(IMG_H - 1)) ? '0 : r_row + 1'b1;
  assign w_last_word  = (r_wcol == WCOL_W'(IMG_W/PPW - 1));
  assign w_last_h     = (r_h == COORD_W'(IMG_W - 1));
  assign w_last_v     = (r_v == COORD_W'(IMG_H - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (w_start_rise) w_state_next = S_PRELOAD;
        S_PRELOAD:   if (w_last_word && r_rows_left == 4'd1) w_state_next = S_ISSUE;
        S_ISSUE:     if (!conv_wait) w_state_next = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (conv_done) begin
            if (w_last_h && w_last_v) w_state_next = S_FINISH;
            else if (w_last_h)        w_state_next = S_ADV_ROW;
            else                      w_state_next = S_ISSUE;
          end
        end
        S_ADV_ROW:   w_state_next = S_PRELOAD;
        S_FINISH:    w_state_next = S_IDLE;
        default:     w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    buf_load = 1'b0;
    conv_req = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_PRELOAD:   begin buf_load = 1'b1; busy = 1'b1; end
      S_ISSUE:     busy = 1'b1;
      S_WAIT_DONE: begin conv_req = 1'b1; busy = 1'b1; end
      S_ADV_ROW:   busy = 1'b1;
      S_FINISH:    done = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_d     <= 1'b0;
      r_next_matrix <= 1'b0;
      r_opcode      <= '0;
      r_rows_left   <= '0;
      r_row         <= '0;
      r_wcol        <= '0;
      r_h           <= '0;
      r_v           <= '0;
    end else begin
      r_start_d     <= start;
      r_next_matrix <= 1'b0;
      if (abort || r_state == S_FINISH) begin
        r_rows_left <= '0;
        r_row       <= '0;
        r_wcol      <= '0;
        r_h         <= '0;
        r_v         <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_rise) begin
              r_opcode    <= opcode;
              r_row       <= w_r0;
              r_wcol      <= '0;
              r_rows_left <= w_k;
            end
          end
          S_PRELOAD: begin
            if (w_last_word) begin
              r_wcol      <= '0;
              r_row       <= w_row_inc;
              r_rows_left <= r_rows_left - 4'd1;
            end else begin
              r_wcol <= r_wcol + 1'b1;
            end
          end
          S_WAIT_DONE: begin
            if (conv_done) begin
              r_next_matrix <= 1'b1;
              if (!w_last_h) begin
                r_h <= r_h + 1'b1;
              end else if (!w_last_v) begin
                r_h <= '0;
                r_v <= r_v + 1'b1;
              end
            end
          end
          S_ADV_ROW: r_rows_left <= 4'd1;
          default:   ;
        endcase
      end
    end
  end

  assign buf_addr    = {r_row, r_wcol};
  assign buf_col     = COORD_W'(32'(r_wcol) * PPW);
  assign next_matrix = r_next_matrix;
  assign conv_inst   = 32'({r_v, r_h, r_opcode});
  assign cur_h       = r_h;
  assign cur_v       = r_v;

endmodule

// File: tb/tb_ipu_frame_sequencer.sv
// Directed bench for ipu_frame_sequencer on an 8x4 frame with a 2-cycle coprocessor.
module tb_ipu_frame_sequencer;

  localparam int IMG_W = 8, IMG_H = 4, PPW = 4, COORD_W = 9, MAX_K = 5;
  localparam int AW = COORD_W + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [3:0]         opcode = '0;
  logic [1:0]         ksize = '0;
  logic               conv_wait = 1'b0;
  logic               conv_done;
  logic [AW-1:0]      buf_addr;
  logic               buf_load;
  logic [COORD_W-1:0] buf_col;
  logic               next_matrix;
  logic               conv_req;
  logic [31:0]        conv_inst;
  logic               busy;
  logic               done;
  logic [COORD_W-1:0] cur_h;
  logic [COORD_W-1:0] cur_v;

  ipu_frame_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PPW(PPW), .COORD_W(COORD_W), .MAX_K(MAX_K)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .opcode(opcode), .ksize(ksize),
    .buf_addr(buf_addr), .buf_load(buf_load), .buf_col(buf_col),
    .next_matrix(next_matrix), .conv_req(conv_req), .conv_inst(conv_inst),
    .conv_wait(conv_wait), .conv_done(conv_done),
    .busy(busy), .done(done), .cur_h(cur_h), .cur_v(cur_v)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state, written only by the monitor process.
  int          n_req = 0, n_nm = 0, n_load = 0, n_done = 0, n_inst_chg = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_inst = '0;
  logic [31:0] inst_73 = '0;
  int          row_log[$];

  // Baselines, written only by the stimulus block.
  int b_req, b_nm, b_load, b_done, b_rows;

  // Coprocessor: conv_done two cycles after conv_req rises, unless overridden.
  logic cp_en = 1'b1;
  logic cp_manual = 1'b0;
  logic cp_auto = 1'b0;
  int   cp_cnt = 0;
  assign conv_done = cp_en ? cp_auto : cp_manual;

  always @(negedge clk) begin
    if (conv_req) begin
      cp_cnt  = cp_cnt + 1;
      cp_auto = (cp_cnt == 2);
    end else begin
      cp_cnt  = 0;
      cp_auto = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (conv_req && !prev_req) begin
      n_req = n_req + 1;
      if (cur_h == 9'd7 && cur_v == 9'd3) inst_73 = conv_inst;
    end
    if (conv_req && prev_req && conv_inst !== prev_inst) n_inst_chg = n_inst_chg + 1;
    if (next_matrix) n_nm = n_nm + 1;
    if (buf_load) begin
      n_load = n_load + 1;
      if (!buf_addr[0]) row_log.push_back(int'(buf_addr[AW-1:1]));
    end
    if (done) n_done = n_done + 1;
    prev_req  = conv_req;
    prev_inst = conv_inst;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark;
    b_req  = n_req;
    b_nm   = n_nm;
    b_load = n_load;
    b_done = n_done;
    b_rows = row_log.size();
  endtask

  function automatic int rows_packed();
    int p = 0;
    for (int i = b_rows; i < row_log.size(); i++) p = (p << 4) | row_log[i];
    return p;
  endfunction

  task automatic pulse_start(input logic [3:0] op, input logic [1:0] ks);
    opcode = op;
    ksize  = ks;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    chk({tag, "_done_seen"}, 64'(done), 64'(1));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_outputs", 64'({busy, done, conv_req, buf_load, next_matrix, buf_addr, buf_col, cur_h, cur_v}), 64'(0));
    chk("rst_inst", 64'(conv_inst), 64'(0));

    // Frame with K=3: preload rows 3,0,1 then single-row loads 2,3,0.
    mark();
    pulse_start(4'd5, 2'd1);
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_first_addr", 64'(buf_addr), 64'(6));
    chk("t1_first_col", 64'(buf_col), 64'(0));
    @(negedge clk);
    chk("t1_second_addr", 64'(buf_addr), 64'(7));
    chk("t1_second_col", 64'(buf_col), 64'(4));
    wait_frame("t1");
    chk("t1_req_count", 64'(n_req - b_req), 64'(32));
    chk("t1_nm_count", 64'(n_nm - b_nm), 64'(32));
    chk("t1_load_count", 64'(n_load - b_load), 64'(12));
    chk("t1_done_count", 64'(n_done - b_done), 64'(1));
    chk("t1_rows", 64'(rows_packed()), 64'(32'h0030_1230));
    chk("t1_inst_7_3", 64'(inst_73), 64'(32'h0000_6075));
    chk("t1_inst_stable", 64'(n_inst_chg), 64'(0));
    chk("t1_coords_cleared", 64'({cur_h, cur_v}), 64'(0));

    // K=2: two preload rows starting at row 3.
    mark();
    pulse_start(4'd5, 2'd0);
    chk("t2_first_addr", 64'(buf_addr), 64'(6));
    wait_frame("t2");
    chk("t2_load_count", 64'(n_load - b_load), 64'(10));
    chk("t2_rows", 64'(rows_packed()), 64'(32'h0003_0123));
    chk("t2_req_count", 64'(n_req - b_req), 64'(32));

    // Coprocessor busy during the first ISSUE.
    conv_wait = 1'b1;
    mark();
    pulse_start(4'd9, 2'd1);
    for (int i = 0; i < 100 && buf_load; i++) @(negedge clk);
    chk("t3_reached_issue", 64'({busy, buf_load}), 64'(2));
    for (int i = 0; i < 5; i++) begin
      chk("t3_req_held_low", 64'(conv_req), 64'(0));
      chk("t3_inst_waiting", 64'(conv_inst), 64'(32'h9));
      @(negedge clk);
    end
    conv_wait = 1'b0;
    @(negedge clk);
    chk("t3_req_after_wait", 64'(conv_req), 64'(1));
    chk("t3_inst_after_wait", 64'(conv_inst), 64'(32'h9));
    wait_frame("t3");
    chk("t3_req_count", 64'(n_req - b_req), 64'(32));

    // Abort in WAIT_DONE at pixel (3,1), stray conv_done right after.
    mark();
    pulse_start(4'd5, 2'd1);
    for (int i = 0; i < 2000 && !(conv_req && cur_h == 9'd3 && cur_v == 9'd1); i++) @(negedge clk);
    chk("t4_reached_pixel", 64'(conv_req), 64'(1));
    abort = 1'b1;
    cp_en = 1'b0;
    @(negedge clk);
    abort     = 1'b0;
    cp_manual = 1'b1;
    chk("t4_idle_after_abort", 64'({busy, conv_req, buf_load, done}), 64'(0));
    chk("t4_coords_cleared", 64'({cur_h, cur_v}), 64'(0));
    @(negedge clk);
    cp_manual = 1'b0;
    @(negedge clk);
    chk("t4_no_next_matrix", 64'(next_matrix), 64'(0));
    chk("t4_nm_count", 64'(n_nm - b_nm), 64'(3 + 8));
    chk("t4_no_done", 64'(n_done - b_done), 64'(0));
    chk("t4_still_idle", 64'(busy), 64'(0));
    cp_en = 1'b1;
    mark();
    pulse_start(4'd5, 2'd1);
    chk("t4_restart_addr", 64'({buf_load, buf_addr}), 64'({1'b1, 10'd6}));
    wait_frame("t4");
    chk("t4_restart_reqs", 64'(n_req - b_req), 64'(32));
    chk("t4_restart_rows", 64'(rows_packed()), 64'(32'h0030_1230));

    // start held high across FINISH, then released and pulsed again.
    mark();
    opcode = 4'd5;
    ksize  = 2'd1;
    start  = 1'b1;
    wait_frame("t5a");
    repeat (200) @(negedge clk);
    chk("t5_single_done", 64'(n_done - b_done), 64'(1));
    chk("t5_idle_while_held", 64'(busy), 64'(0));
    chk("t5_single_reqs", 64'(n_req - b_req), 64'(32));
    start = 1'b0;
    @(negedge clk);
    pulse_start(4'd5, 2'd1);
    wait_frame("t5b");
    chk("t5_two_done", 64'(n_done - b_done), 64'(2));
    chk("t5_two_reqs", 64'(n_req - b_req), 64'(64));
    chk("t5_two_loads", 64'(n_load - b_load), 64'(24));
    chk("t5_two_nm", 64'(n_nm - b_nm), 64'(64));

    // Asynchronous reset mid-PRELOAD.
    pulse_start(4'd5, 2'd1);
    @(negedge clk);
    chk("t6_in_preload", 64'({buf_load, buf_addr}), 64'({1'b1, 10'd7}));
    #1 reset = 1'b1;
    #1;
    chk("t6_async_clear", 64'({busy, done, conv_req, buf_load, next_matrix, buf_addr, buf_col}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_stays_idle", 64'({busy, buf_load}), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
